// File: rtl/master_bridge_async_fifo_rd_ctrl.sv
// ============================================================================
// master_bridge_async_fifo_rd_ctrl - async FIFO read-side controller
// (Gray sync, empty flag, FWFT output). Optional level: MASTER_BRIDGE_FIFO_RD_LEVEL_EN
// Revision: 1.0
// ============================================================================
`default_nettype none

module master_bridge_async_fifo_rd_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  CLK,
  input  logic                  i_r_rst,
  input  logic [ADDR_WIDTH:0]   i_wr_ptr_gray,
  output logic [ADDR_WIDTH:0]   o_rd_ptr_gray,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  input  logic                  i_ready,
`ifdef MASTER_BRIDGE_FIFO_RD_LEVEL_EN
  output logic [ADDR_WIDTH:0]   o_level,
`endif
  output logic                  o_empty
);

  localparam int c_PTR_W = ADDR_WIDTH + 1;

  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_HOLD  = 1'b1
  } state_t;

  state_t                r_state;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic [c_PTR_W-1:0]    r_wr_gray_s1;
  logic [c_PTR_W-1:0]    r_wr_gray_s2;
  logic [c_PTR_W-1:0]    r_rd_ptr_bin;
  logic [c_PTR_W-1:0]    r_rd_ptr_gray;

  logic [c_PTR_W-1:0]    w_next_bin;
  logic [c_PTR_W-1:0]    w_next_gray;
  logic                  w_empty;
  logic                  w_pop;

  // Plain two-flop synchroniser; nothing may sit between the stages.
  always_ff @(posedge CLK or posedge i_r_rst) begin
    if (i_r_rst) begin
      r_wr_gray_s1 <= '0;
      r_wr_gray_s2 <= '0;
    end else begin
      r_wr_gray_s1 <= i_wr_ptr_gray;
      r_wr_gray_s2 <= r_wr_gray_s1;
    end
  end

  assign w_next_bin  = r_rd_ptr_bin + c_PTR_W'(1);
  assign w_next_gray = w_next_bin ^ (w_next_bin >> 1);
  assign w_empty     = (r_rd_ptr_gray == r_wr_gray_s2);
  assign w_pop       = ~w_empty & (~r_valid | i_ready);

  always_ff @(posedge CLK or posedge i_r_rst) begin
    if (i_r_rst) begin
      r_rd_ptr_bin  <= '0;
      r_rd_ptr_gray <= '0;
    end else if (w_pop) begin
      r_rd_ptr_bin  <= w_next_bin;
      r_rd_ptr_gray <= w_next_gray;
    end
  end

  // Output stage: a pop always refills the register, so HOLD persists
  // across back-to-back handshakes at one word per cycle.
  always_ff @(posedge CLK or posedge i_r_rst) begin
    if (i_r_rst) begin
      r_state <= S_EMPTY;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_pop) begin
            r_state <= S_HOLD;
            r_valid <= 1'b1;
            r_data  <= i_rd_data;
          end
        end
        S_HOLD: begin
          if (i_ready) begin
            if (w_pop) begin
              r_data <= i_rd_data;
            end else begin
              r_state <= S_EMPTY;
              r_valid <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= S_EMPTY;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_rd_ptr_gray = r_rd_ptr_gray;
  assign o_rd_addr     = r_rd_ptr_bin[ADDR_WIDTH-1:0];
  assign o_valid       = r_valid;
  assign o_data        = r_data;
  assign o_empty       = w_empty;

`ifdef MASTER_BRIDGE_FIFO_RD_LEVEL_EN
  logic [c_PTR_W-1:0] w_wr_bin_s2;

  always_comb begin
    w_wr_bin_s2 = '0;
    w_wr_bin_s2[c_PTR_W-1] = r_wr_gray_s2[c_PTR_W-1];
    for (int i = c_PTR_W - 2; i >= 0; i--) begin
      w_wr_bin_s2[i] = w_wr_bin_s2[i+1] ^ r_wr_gray_s2[i];
    end
  end

  assign o_level = w_wr_bin_s2 - r_rd_ptr_bin;
`endif

endmodule

`default_nettype wire

// File: tb/tb_master_bridge_async_fifo_rd_ctrl.sv
// ============================================================================
// tb_master_bridge_async_fifo_rd_ctrl - self-checking bench with queue model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_master_bridge_async_fifo_rd_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int PW    = AW + 1;
  localparam int DEPTH = 1 << AW;

  logic          CLK = 1'b0;
  logic          i_r_rst;
  logic [PW-1:0] i_wr_ptr_gray;
  logic [PW-1:0] o_rd_ptr_gray;
  logic [AW-1:0] o_rd_addr;
  logic [DW-1:0] i_rd_data;
  logic          o_valid;
  logic [DW-1:0] o_data;
  logic          i_ready;
  logic          o_empty;
`ifdef MASTER_BRIDGE_FIFO_RD_LEVEL_EN
  logic [PW-1:0] o_level;
`endif

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] exp_q [$];
  int            wr_cnt;
  int            rd_done;
  int            n_cmp = 0;
  int            n_err = 0;

  always #5 CLK = ~CLK;
  assign i_rd_data = mem[o_rd_addr];

  master_bridge_async_fifo_rd_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .CLK          (CLK),
    .i_r_rst      (i_r_rst),
    .i_wr_ptr_gray(i_wr_ptr_gray),
    .o_rd_ptr_gray(o_rd_ptr_gray),
    .o_rd_addr    (o_rd_addr),
    .i_rd_data    (i_rd_data),
    .o_valid      (o_valid),
    .o_data       (o_data),
    .i_ready      (i_ready),
`ifdef MASTER_BRIDGE_FIFO_RD_LEVEL_EN
    .o_level      (o_level),
`endif
    .o_empty      (o_empty)
  );

  function automatic logic [PW-1:0] gray(input int b);
    logic [PW-1:0] v;
    v = PW'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_model();
    wr_cnt  = 0;
    rd_done = 0;
    exp_q.delete();
    i_wr_ptr_gray = '0;
    i_ready = 1'b0;
  endtask

  task automatic do_reset();
    i_r_rst = 1'b1;
    clear_model();
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    tick();
    tick();
    i_r_rst = 1'b0;
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    mem[wr_cnt % DEPTH] = d;
    exp_q.push_back(d);
    wr_cnt++;
    i_wr_ptr_gray = gray(wr_cnt);
  endtask

  // One clock of stimulus: optional write, chosen ready, model-side
  // handshake accounting and hold-stability check.
  task automatic cycle(input bit do_wr, input bit rdy);
    logic [DW-1:0] held;
    bit            hold_chk;
    i_ready = rdy;
    if (do_wr && exp_q.size() < DEPTH) push_word(DW'($urandom));
    hold_chk = o_valid && !rdy;
    held     = o_data;
    if (o_valid && rdy) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL handshake_extra: got word %h, required none", o_data);
      end else begin
        if (o_data !== exp_q[0]) begin
          n_err++;
          $display("FAIL handshake_data: got %h, required %h", o_data, exp_q[0]);
        end
        void'(exp_q.pop_front());
        rd_done++;
      end
    end
    tick();
    if (hold_chk) begin
      n_cmp++;
      if (o_valid !== 1'b1 || o_data !== held) begin
        n_err++;
        $display("FAIL hold_stable: got valid=%b data=%h, required valid=1 data=%h",
                 o_valid, o_data, held);
      end
    end
  endtask

  task automatic test_reset();
    i_r_rst = 1'b1;
    clear_model();
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    #3;
    n_cmp++;
    if (o_valid !== 1'b0 || o_empty !== 1'b1 || o_data !== '0 ||
        o_rd_addr !== '0 || o_rd_ptr_gray !== '0) begin
      n_err++;
      $display("FAIL reset_values: got v=%b e=%b d=%h a=%h g=%b, required v=0 e=1 d=00 a=0 g=0000",
               o_valid, o_empty, o_data, o_rd_addr, o_rd_ptr_gray);
    end
    tick();
    i_r_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      i_ready = 1'(i % 2);
      tick();
    end
    n_cmp++;
    if (o_valid !== 1'b0 || o_empty !== 1'b1 || o_rd_addr !== '0 || o_rd_ptr_gray !== '0) begin
      n_err++;
      $display("FAIL idle_values: got v=%b e=%b a=%h g=%b, required v=0 e=1 a=0 g=0000",
               o_valid, o_empty, o_rd_addr, o_rd_ptr_gray);
    end
`ifdef MASTER_BRIDGE_FIFO_RD_LEVEL_EN
    n_cmp++;
    if (o_level !== '0) begin
      n_err++;
      $display("FAIL idle_level: got %0d, required 0", o_level);
    end
`endif
  endtask

  task automatic test_latency();
    do_reset();
    mem[0] = 8'hA5;
    i_wr_ptr_gray = 4'b0001;
    tick();
    n_cmp++;
    if (o_empty !== 1'b1 || o_valid !== 1'b0) begin
      n_err++;
      $display("FAIL latency_edge1: got e=%b v=%b, required e=1 v=0", o_empty, o_valid);
    end
    tick();
    n_cmp++;
    if (o_empty !== 1'b0 || o_valid !== 1'b0) begin
      n_err++;
      $display("FAIL latency_edge2: got e=%b v=%b, required e=0 v=0", o_empty, o_valid);
    end
    tick();
    n_cmp++;
    if (o_valid !== 1'b1 || o_data !== 8'hA5 || o_rd_ptr_gray !== 4'b0001 || o_empty !== 1'b1) begin
      n_err++;
      $display("FAIL latency_edge3: got v=%b d=%h g=%b e=%b, required v=1 d=a5 g=0001 e=1",
               o_valid, o_data, o_rd_ptr_gray, o_empty);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (o_valid !== 1'b1 || o_data !== 8'hA5) begin
        n_err++;
        $display("FAIL latency_hold%0d: got v=%b d=%h, required v=1 d=a5", i, o_valid, o_data);
      end
    end
    i_ready = 1'b1;
    tick();
    n_cmp++;
    if (o_valid !== 1'b0) begin
      n_err++;
      $display("FAIL latency_consume: got v=%b, required 0", o_valid);
    end
  endtask

  task automatic test_burst();
    do_reset();
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(8'h10 + i);
    wr_cnt = 8;
    i_wr_ptr_gray = 4'b1100;
    i_ready = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (o_empty !== 1'b0 || o_valid !== 1'b0) begin
      n_err++;
      $display("FAIL burst_pre: got e=%b v=%b, required e=0 v=0", o_empty, o_valid);
    end
`ifdef MASTER_BRIDGE_FIFO_RD_LEVEL_EN
    n_cmp++;
    if (o_level !== 4'd8) begin
      n_err++;
      $display("FAIL burst_level: got %0d, required 8", o_level);
    end
`endif
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      n_cmp++;
      if (o_valid !== 1'b1 || o_data !== DW'(8'h10 + i)) begin
        n_err++;
        $display("FAIL burst_word%0d: got v=%b d=%h, required v=1 d=%h",
                 i, o_valid, o_data, DW'(8'h10 + i));
      end
    end
    tick();
    n_cmp++;
    if (o_valid !== 1'b0 || o_empty !== 1'b1 || o_rd_ptr_gray !== 4'b1100) begin
      n_err++;
      $display("FAIL burst_end: got v=%b e=%b g=%b, required v=0 e=1 g=1100",
               o_valid, o_empty, o_rd_ptr_gray);
    end
    rd_done = 8;
  endtask

  task automatic test_wrap();
    logic [PW-1:0] prev_g;
    bit            saw_wrap;
    int            budget;
    saw_wrap = 1'b0;
    prev_g   = o_rd_ptr_gray;
    budget   = 0;
    while ((wr_cnt < 28 || exp_q.size() != 0 || o_valid) && budget < 300) begin
      cycle(wr_cnt < 28 && ($urandom % 3 != 0), 1'b1);
      budget++;
      n_cmp++;
      if (o_rd_ptr_gray !== gray(rd_done + int'(o_valid))) begin
        n_err++;
        $display("FAIL wrap_rdgray: got %b, required %b", o_rd_ptr_gray,
                 gray(rd_done + int'(o_valid)));
      end
      if (prev_g == 4'b1000 && o_rd_ptr_gray == 4'b0000) saw_wrap = 1'b1;
      prev_g = o_rd_ptr_gray;
    end
    n_cmp++;
    if (!saw_wrap || rd_done != 28 || o_empty !== 1'b1) begin
      n_err++;
      $display("FAIL wrap_end: got wrap=%0d reads=%0d e=%b, required wrap=1 reads=28 e=1",
               saw_wrap, rd_done, o_empty);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0);
    n_cmp++;
    if (o_valid !== 1'b1 || o_empty !== 1'b0 || o_rd_addr !== 3'd1) begin
      n_err++;
      $display("FAIL rstmid_pre: got v=%b e=%b a=%h, required v=1 e=0 a=1",
               o_valid, o_empty, o_rd_addr);
    end
    #2;
    i_r_rst = 1'b1;
    #1;
    n_cmp++;
    if (o_valid !== 1'b0 || o_data !== '0 || o_empty !== 1'b1 ||
        o_rd_ptr_gray !== '0 || o_rd_addr !== '0) begin
      n_err++;
      $display("FAIL rstmid_async: got v=%b d=%h e=%b g=%b a=%h, required v=0 d=00 e=1 g=0000 a=0",
               o_valid, o_data, o_empty, o_rd_ptr_gray, o_rd_addr);
    end
    clear_model();
    tick();
    i_r_rst = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    n_cmp++;
    if (o_valid !== 1'b0 || o_empty !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_after: got v=%b e=%b, required v=0 e=1", o_valid, o_empty);
    end
  endtask

  task automatic test_ready_toggle();
    int base;
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);
    base = rd_done;
    for (int i = 0; i < 12; i++) cycle(1'b0, (i % 2) == 0);
    n_cmp++;
    if (rd_done - base != 4 || exp_q.size() != 0 || o_valid !== 1'b0) begin
      n_err++;
      $display("FAIL toggle_count: got delivered=%0d left=%0d v=%b, required 4 0 0",
               rd_done - base, exp_q.size(), o_valid);
    end
  endtask

  task automatic test_back_to_back_random();
    do_reset();
    for (int i = 0; i < 400; i++) cycle($urandom % 3 != 0, $urandom % 4 != 0);
    for (int i = 0; i < 40; i++) cycle(1'b0, 1'b1);
    n_cmp++;
    if (exp_q.size() != 0 || o_valid !== 1'b0 || o_empty !== 1'b1) begin
      n_err++;
      $display("FAIL random_drain: got left=%0d v=%b e=%b, required 0 0 1",
               exp_q.size(), o_valid, o_empty);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_r_rst       = 1'b1;
    i_ready       = 1'b0;
    i_wr_ptr_gray = '0;
    test_reset();
    test_latency();
    test_burst();
    test_wrap();
    test_reset_mid();
    test_ready_toggle();
    test_back_to_back_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/master_bridge_async_fifo_rd_ctrl.md
# master_bridge_async_fifo_rd_ctrl

Read-side controller for the master bridge async FIFO. It runs in the read clock domain and owns the read pointer. It synchronises the write-domain Gray pointer and derives the empty condition. It pops words from the FIFO storage's combinational read port into a registered first-word-fall-through output stage with a valid/ready handshake toward the AXI master logic.

## Interface
- DATA_WIDTH, 8, width of one FIFO word.
- ADDR_WIDTH, 3, storage address width; FIFO depth is 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.

- CLK  input  1  read-domain clock; all state on rising edge.
- i_r_rst  input  1  reset, asynchronous assert, active-high; releases synchronously to CLK externally.
- i_wr_ptr_gray  input  ADDR_WIDTH+1  write pointer, Gray-coded, from write domain (asynchronous to CLK).
- o_rd_ptr_gray  output  ADDR_WIDTH+1  registered read pointer, Gray-coded, to write domain.
- o_rd_addr  output  ADDR_WIDTH  storage read address = rd_ptr_bin[ADDR_WIDTH-1:0].
- i_rd_data  input  DATA_WIDTH  storage read data (combinational from o_rd_addr).
- o_valid  output  1  output word valid.
- o_data  output  DATA_WIDTH  output word.
- i_ready  input  1  consumer accepts o_data this cycle.
- o_empty  output  1  no unread word in storage (output register excluded).
- o_level  output  ADDR_WIDTH+1  storage occupancy (only with MASTER_BRIDGE_FIFO_RD_LEVEL_EN).

## Operation
- Sync: two-flop synchroniser wr_gray_s1 -> wr_gray_s2 on i_wr_ptr_gray; no logic between the stages.
- State: rd_ptr_bin, rd_ptr_gray (both registered, updated together), o_valid, o_data.
- empty_int = (rd_ptr_gray == wr_gray_s2); o_empty = empty_int.
- pop = ~empty_int & (~o_valid | i_ready).
- On pop: o_data <= i_rd_data; o_valid <= 1; rd_ptr_bin <= rd_ptr_bin + 1; rd_ptr_gray <= next_bin ^ (next_bin >> 1).
- Else if o_valid & i_ready: o_valid <= 0; o_data holds.
- Otherwise all state holds.
- The output stage is two-state: EMPTY (o_valid=0) and HOLD (o_valid=1).
  - EMPTY -> HOLD on pop.
  - HOLD -> HOLD on handshake with pop (back-to-back, one word per cycle).
  - HOLD -> EMPTY on handshake without pop.
- Pointer arithmetic: modulo 2**(ADDR_WIDTH+1); wrap from all-ones to 0 is a normal increment. The MSB distinguishes full from empty in the write domain.
- o_data is stable while o_valid & ~i_ready; i_ready while o_valid=0 has no effect.
- Full is not a read-domain concern.

## Timing
- Reset values: rd_ptr_bin=0, o_rd_ptr_gray=0, wr_gray_s1/s2=0, o_valid=0, o_data=0, o_empty=1, o_level=0.
- Latency, write pointer to output: i_wr_ptr_gray change, then edge 1 to s1, edge 2 to s2 (o_empty falls), edge 3 pop (o_valid=1). Data is visible 3 CLK edges after the pointer change.
- Sustained throughput: 1 word/cycle while i_ready=1 and storage is non-empty.
- Read pointer update to o_rd_ptr_gray: same edge as pop. The write domain sees it after its own 2-flop synchroniser.
- Reset mid-operation: immediate asynchronous clear of all state; the in-flight o_data word and unread entries are discarded. The write domain must be reset in the same event.
- i_wr_ptr_gray must change by at most one bit per write clock; this is guaranteed by the write controller.

## Configuration
- MASTER_BRIDGE_FIFO_RD_LEVEL_EN defined:
  - wr_gray_s2 is Gray-to-binary converted.
  - o_level = wr_bin_s2 - rd_ptr_bin, modulo 2**(ADDR_WIDTH+1), combinational from registers; range 0..2**ADDR_WIDTH.
- Not defined: o_level port and converter absent; all other behaviour identical.

## Test plan
- Reset, then idle with i_wr_ptr_gray=0: o_valid=0, o_empty=1, o_rd_addr=0, o_rd_ptr_gray=0.
- Storage word0=0xA5, set i_wr_ptr_gray=4'b0001 with i_ready=0: o_empty=0 after 2 edges; o_valid=1 and o_data=0xA5 after 3 edges; o_rd_ptr_gray=0001. o_data holds 0xA5 for 5 cycles with i_ready=0.
- Storage 0x10..0x17, i_wr_ptr_gray=Gray(8)=4'b1100, i_ready=1: o_data 0x10..0x17 on 8 consecutive cycles; then o_empty=1 and o_valid=0; o_level=8 (with macro) before first pop.
- Wrap: 20 writes/reads in steps with i_ready=1. rd_ptr passes 15 -> 0, with o_rd_ptr_gray 4'b1000 -> 4'b0000, and no data is lost or duplicated.
- Assert i_r_rst while o_valid=1 and 3 words pending: all outputs return to reset values asynchronously, before the next CLK edge.
- i_ready toggling 1,0,1,0 with 4 words pending: each word is delivered exactly once, in order; o_data is unchanged while i_ready=0.
